// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack speculation
// controller: log operation codes, log entry layout, controller states.
package ras_pkg;

    // Default capacity of the controlled return address stack.
    localparam int RAS_DEPTH = 8;

    // Speculative operation recorded for each accepted call/ret.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } ras_op_t;

    // One log slot: the operation and the address needed to undo it.
    typedef struct packed {
        ras_op_t     op;
        logic [15:0] data;
    } ras_log_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        UNWIND = 1'b1
    } ras_ctrl_state_t;

endpackage

// File: rtl/ras_log.sv
// Circular deque of speculative RAS operations. New entries enter at the
// tail, commits retire from the head, and flush recovery removes from the
// tail (youngest first). DEPTH must be a power of two so pointers wrap
// naturally.
module ras_log
    import ras_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_tail,
    input  ras_log_entry_t push_entry,
    input  logic           pop_tail,
    input  logic           pop_head,
    output ras_log_entry_t tail_entry,
    output logic [PW:0]    count
);

    localparam int CW = PW + 1;

    ras_log_entry_t mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  tail_prev;

    // Youngest valid entry sits just below the tail pointer.
    assign tail_prev  = tail - PW'(1);
    assign tail_entry = mem[tail_prev];

    // Entry storage write.
    // NOTE: the storage array is deliberately not reset; head/tail/count alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (push_tail) begin
            mem[tail] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; caller never pushes and pops the tail together.
    // NOTE: sequential state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_tail) begin
                tail <= tail + PW'(1);
            end else if (pop_tail) begin
                tail <= tail_prev;
            end
            if (pop_head) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push_tail) - CW'(pop_tail) - CW'(pop_head);
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Speculation controller for the fetch return address stack. Turns call/ret
// hints into RAS push/pop commands, predicts return targets with zero
// latency, logs every speculative operation, and on flush unwinds the
// uncommitted operations one per cycle.
// Optional build macro: RAS_CTRL_STATS_EN adds saturating statistics ports.
module ras_ctrl #(
    parameter int LOG_DEPTH = 4,
    parameter int RAS_DEPTH = ras_pkg::RAS_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_call,
    input  logic        fetch_ret,
    input  logic [15:0] fetch_pc,
    input  logic        commit_valid,
    input  logic        flush,
    input  logic [15:0] ras_top,
    output logic        ras_push,
    output logic [15:0] ras_data,
    output logic        ras_pop,
    output logic        pred_valid,
    output logic [15:0] pred_target,
    output logic        fetch_stall,
    output logic        ovf_err
`ifdef RAS_CTRL_STATS_EN
    ,
    output logic [15:0] stat_calls,
    output logic [15:0] stat_rets,
    output logic [15:0] stat_unwind_cycles
`endif
);

    import ras_pkg::*;

    localparam int CW = $clog2(LOG_DEPTH) + 1;
    localparam int DW = $clog2(RAS_DEPTH + 1);

    ras_ctrl_state_t state, state_nxt;
    logic [DW-1:0]   spec_depth, depth_nxt;
    logic            ovf_nxt;

    logic            log_push, log_pop_tail, log_pop_head;
    ras_log_entry_t  log_entry, tail_entry;
    logic [CW-1:0]   log_count;

    ras_log #(.DEPTH(LOG_DEPTH)) u_log (
        .clk        (clk),
        .rst        (rst),
        .push_tail  (log_push),
        .push_entry (log_entry),
        .pop_tail   (log_pop_tail),
        .pop_head   (log_pop_head),
        .tail_entry (tail_entry),
        .count      (log_count)
    );

    // Next-state, RAS command and log command decode.
    // NOTE: every signal gets a default at the top of this block so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        depth_nxt    = spec_depth;
        ovf_nxt      = ovf_err;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        ras_data     = 16'h0;
        pred_valid   = 1'b0;
        pred_target  = 16'h0;
        fetch_stall  = 1'b0;
        log_push     = 1'b0;
        log_pop_tail = 1'b0;
        log_pop_head = 1'b0;
        log_entry    = '{op: NONE, data: 16'h0};

        case (state)
            RUN: begin
                log_pop_head = commit_valid && (log_count != '0);
                if (flush) begin
                    // Fetch is wrong-path here; unwind only if entries survive the commit.
                    if (log_count != CW'(log_pop_head)) begin
                        state_nxt = UNWIND;
                    end
                end else if (fetch_call || fetch_ret) begin
                    // Fullness uses the pre-commit count so a same-cycle commit cannot release the stall.
                    if (log_count == CW'(LOG_DEPTH)) begin
                        fetch_stall = 1'b1;
                    end else begin
                        log_push = 1'b1;
                        if (fetch_ret) begin
                            if (fetch_call) begin
                                ovf_nxt = 1'b1;
                            end
                            if (spec_depth != '0) begin
                                ras_pop     = 1'b1;
                                pred_valid  = 1'b1;
                                pred_target = ras_top;
                                log_entry   = '{op: POP, data: ras_top};
                                depth_nxt   = spec_depth - DW'(1);
                            end
                        end else if (spec_depth != DW'(RAS_DEPTH)) begin
                            ras_push  = 1'b1;
                            ras_data  = fetch_pc + 16'd1;
                            log_entry = '{op: PUSH, data: fetch_pc + 16'd1};
                            depth_nxt = spec_depth + DW'(1);
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end
            end

            UNWIND: begin
                fetch_stall  = 1'b1;
                log_pop_tail = 1'b1;
                case (tail_entry.op)
                    PUSH: begin
                        ras_pop   = 1'b1;
                        depth_nxt = spec_depth - DW'(1);
                    end
                    POP: begin
                        ras_push  = 1'b1;
                        ras_data  = tail_entry.data;
                        depth_nxt = spec_depth + DW'(1);
                    end
                    default: ;
                endcase
                if (log_count == CW'(1)) begin
                    state_nxt = RUN;
                end
            end

            default: state_nxt = RUN;
        endcase
    end

    // FSM state, speculative depth and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            spec_depth <= '0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            spec_depth <= depth_nxt;
            ovf_err    <= ovf_nxt;
        end
    end

`ifdef RAS_CTRL_STATS_EN
    // Saturating counters: fetch-issued pushes and pops, and recovery cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_calls         <= 16'h0;
            stat_rets          <= 16'h0;
            stat_unwind_cycles <= 16'h0;
        end else begin
            if (state == RUN && ras_push && stat_calls != 16'hFFFF) begin
                stat_calls <= stat_calls + 16'd1;
            end
            if (state == RUN && ras_pop && stat_rets != 16'hFFFF) begin
                stat_rets <= stat_rets + 16'd1;
            end
            if (state == UNWIND && stat_unwind_cycles != 16'hFFFF) begin
                stat_unwind_cycles <= stat_unwind_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl. Contains a simple array RAS driven by
// the controller's commands and a queue-based reference model of the log
// and of the expected stack contents.
module tb_ras_ctrl;

    import ras_pkg::*;

    localparam int LOGD = 4;
    localparam int RASD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_call, fetch_ret, commit_valid, flush;
    logic [15:0] fetch_pc;
    logic [15:0] ras_top;
    logic        ras_push, ras_pop, pred_valid, fetch_stall, ovf_err;
    logic [15:0] ras_data, pred_target;
`ifdef RAS_CTRL_STATS_EN
    logic [15:0] stat_calls, stat_rets, stat_unwind_cycles;
    int          m_calls, m_rets, m_unw_cycles;
`endif

    always #5 clk = ~clk;

    ras_ctrl #(.LOG_DEPTH(LOGD), .RAS_DEPTH(RASD)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_call   (fetch_call),
        .fetch_ret    (fetch_ret),
        .fetch_pc     (fetch_pc),
        .commit_valid (commit_valid),
        .flush        (flush),
        .ras_top      (ras_top),
        .ras_push     (ras_push),
        .ras_data     (ras_data),
        .ras_pop      (ras_pop),
        .pred_valid   (pred_valid),
        .pred_target  (pred_target),
        .fetch_stall  (fetch_stall),
        .ovf_err      (ovf_err)
`ifdef RAS_CTRL_STATS_EN
        ,
        .stat_calls         (stat_calls),
        .stat_rets          (stat_rets),
        .stat_unwind_cycles (stat_unwind_cycles)
`endif
    );

    // Bench-side RAS that obeys whatever the controller commands.
    logic [15:0] stk [RASD];
    int          stk_n;
    assign ras_top = (stk_n > 0) ? stk[stk_n-1] : 16'h0;

    // Reference model: log as a deque, expected RAS contents as a stack.
    ras_log_entry_t mq [$];
    logic [15:0]    m_ras [$];
    logic           m_ovf;
    bit             m_unw;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        fetch_call = 1'b0; fetch_ret = 1'b0; fetch_pc = 16'h0;
        commit_valid = 1'b0; flush = 1'b0;
        stk_n = 0;
        mq.delete();
        m_ras.delete();
        m_ovf = 1'b0;
        m_unw = 1'b0;
`ifdef RAS_CTRL_STATS_EN
        m_calls = 0; m_rets = 0; m_unw_cycles = 0;
`endif
        #1;
        check("rst_push",  ras_push,    16'h0);
        check("rst_pop",   ras_pop,     16'h0);
        check("rst_data",  ras_data,    16'h0);
        check("rst_pv",    pred_valid,  16'h0);
        check("rst_tgt",   pred_target, 16'h0);
        check("rst_stall", fetch_stall, 16'h0);
        check("rst_ovf",   ovf_err,     16'h0);
`ifdef RAS_CTRL_STATS_EN
        check("rst_scalls", stat_calls,         16'h0);
        check("rst_srets",  stat_rets,          16'h0);
        check("rst_sunw",   stat_unwind_cycles, 16'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict and compare outputs, advance models.
    task automatic step(input logic call, input logic ret, input logic [15:0] pc,
                        input logic com, input logic fl);
        ras_log_entry_t e;
        logic           e_push, e_pop, e_pv, e_stall, n_ovf;
        logic [15:0]    e_data, e_tgt;
        logic           s_push, s_pop;
        logic [15:0]    s_data;
        bit             was_unw;

        @(negedge clk);
        fetch_call = call; fetch_ret = ret; fetch_pc = pc;
        commit_valid = com; flush = fl;
        #1;

        e_push = 1'b0; e_pop = 1'b0; e_pv = 1'b0; e_stall = 1'b0;
        e_data = 16'h0; e_tgt = 16'h0;
        n_ovf = m_ovf;
        was_unw = m_unw;

        if (m_unw) begin
            e = mq.pop_back();
            e_stall = 1'b1;
            if (e.op == PUSH) begin
                e_pop = 1'b1;
            end else if (e.op == POP) begin
                e_push = 1'b1;
                e_data = e.data;
            end
            if (mq.size() == 0) m_unw = 1'b0;
        end else if (fl) begin
            if (com && mq.size() != 0) void'(mq.pop_front());
            if (mq.size() != 0) m_unw = 1'b1;
        end else if ((call || ret) && mq.size() == LOGD) begin
            e_stall = 1'b1;
            if (com) void'(mq.pop_front());
        end else begin
            if (com && mq.size() != 0) void'(mq.pop_front());
            if (ret) begin
                if (call) n_ovf = 1'b1;
                if (m_ras.size() != 0) begin
                    e_pop = 1'b1;
                    e_pv  = 1'b1;
                    e_tgt = m_ras[$];
                    mq.push_back('{op: POP, data: e_tgt});
                end else begin
                    mq.push_back('{op: NONE, data: 16'h0});
                end
            end else if (call) begin
                if (m_ras.size() < RASD) begin
                    e_push = 1'b1;
                    e_data = pc + 16'd1;
                    mq.push_back('{op: PUSH, data: e_data});
                end else begin
                    n_ovf = 1'b1;
                    mq.push_back('{op: NONE, data: 16'h0});
                end
            end
        end

        check("ras_push",    ras_push,    16'(e_push));
        check("ras_pop",     ras_pop,     16'(e_pop));
        if (e_push) check("ras_data", ras_data, e_data);
        check("pred_valid",  pred_valid,  16'(e_pv));
        if (e_pv) check("pred_target", pred_target, e_tgt);
        check("fetch_stall", fetch_stall, 16'(e_stall));
        check("ovf_err",     ovf_err,     16'(m_ovf));
        check("ras_occ",     16'(stk_n),  16'(m_ras.size()));
`ifdef RAS_CTRL_STATS_EN
        check("stat_calls",  stat_calls,         16'(m_calls));
        check("stat_rets",   stat_rets,          16'(m_rets));
        check("stat_unwind", stat_unwind_cycles, 16'(m_unw_cycles));
`endif

        s_push = ras_push; s_pop = ras_pop; s_data = ras_data;
        @(posedge clk);
        #1;
        if (s_push && stk_n < RASD) begin
            stk[stk_n] = s_data;
            stk_n++;
        end else if (s_pop && stk_n > 0) begin
            stk_n--;
        end
        if (e_push) m_ras.push_back(e_data);
        if (e_pop)  void'(m_ras.pop_back());
        m_ovf = n_ovf;
`ifdef RAS_CTRL_STATS_EN
        if (!was_unw && e_push) m_calls++;
        if (!was_unw && e_pop)  m_rets++;
        if (was_unw)            m_unw_cycles++;
`endif
    endtask

    task automatic idle(input logic com);
        step(1'b0, 1'b0, 16'h0, com, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        fetch_call = 1'b0; fetch_ret = 1'b0; fetch_pc = 16'h0;
        commit_valid = 1'b0; flush = 1'b0;
        stk_n = 0;
        m_ovf = 1'b0;
        m_unw = 1'b0;

        // Nested calls then returns: predictions come back in LIFO order.
        do_reset();
        step(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Overflow at full depth, then a log that fills and stalls fetch.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'(16'h1000 + i * 16), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h2000 + i * 16), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Commit one op, speculate two more, flush: restore then predict committed return.
        do_reset();
        step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b0, 16'h0020, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);

        // Return on an empty stack logs an idle op; flush spends one cycle on it.
        do_reset();
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Reset during the second cycle of a four-entry unwind.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0300 + i * 4), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(1'b0);
        do_reset();
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0400, 1'b0, 1'b0);

        // Three calls, one return (with a commit), then a three-entry flush.
        do_reset();
        step(1'b1, 1'b0, 16'h0500, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0600, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0700, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0);
`ifdef RAS_CTRL_STATS_EN
        check("stats_calls_final", stat_calls,         16'd3);
        check("stats_rets_final",  stat_rets,          16'd1);
        check("stats_unw_final",   stat_unwind_cycles, 16'd3);
`endif

        // Randomized traffic including simultaneous call+ret, commits and flushes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic c, t;
            r = int'($urandom_range(0, 15));
            c = (r < 6) || (r == 15);
            t = (r >= 6 && r < 11) || (r == 15);
            step(c, t, 16'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Speculation controller for the 8-entry return address stack used by fetch. Decodes predecoded call/return hints into RAS push/pop commands and supplies the predicted return target. Logs every speculative stack operation and retires log entries in order on commit. On a pipeline flush, it unwinds the uncommitted operations one per cycle, restoring the RAS to its committed contents.

## Interface
- `LOG_DEPTH`, default 4: uncommitted speculative ops tracked; power of two.
- `RAS_DEPTH`, default 8: capacity of the controlled RAS.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `fetch_call`  in  1  fetched instruction is a call.
- `fetch_ret`  in  1  fetched instruction is a return.
- `fetch_pc`  in  16  PC of fetched instruction.
- `commit_valid`  in  1  oldest call/ret retired; one log entry per pulse.
- `flush`  in  1  mispredict; discard all uncommitted ops.
- `ras_top`  in  16  RAS `top_of_stack`.
- `ras_push`  out  1  RAS push.
- `ras_data`  out  16  RAS `new_data`.
- `ras_pop`  out  1  RAS pop.
- `pred_valid`  out  1  `pred_target` usable this cycle.
- `pred_target`  out  16  predicted return address.
- `fetch_stall`  out  1  fetch must hold its call/ret.
- `ovf_err`  out  1  sticky: call dropped at full depth, or call+ret same cycle.

## Operation
- Log entry: `op` {`NONE`, `PUSH`, `POP`} plus 16-bit `data`. The log is a circular deque with a head pointer, a tail pointer, and a count.
- `spec_depth` counter, range 0..`RAS_DEPTH`: tracks RAS occupancy.
- FSM `RUN`:
  - Call with depth < `RAS_DEPTH`: `ras_push=1`, `ras_data=fetch_pc+1` (mod 2^16). Log `PUSH`; `spec_depth++`.
  - Call at full depth: no push. Log `NONE`; set `ovf_err`.
  - Ret with depth > 0: `ras_pop=1`, `pred_valid=1`, `pred_target=ras_top`. Log `POP` with `data=ras_top`; `spec_depth--`.
  - Ret at depth 0: no pop, `pred_valid=0`. Log `NONE`.
  - Call and ret both high: handled as ret only; set `ovf_err`.
  - Log full (count == `LOG_DEPTH`) with call/ret pending: `fetch_stall=1`. Nothing is issued or logged. A commit in the same cycle does not release the stall until the next cycle.
  - `commit_valid`: head++ and count--. A commit with count 0 is ignored.
- Transition `RUN`→`UNWIND`: on `flush` when the log is non-empty after this cycle's commit. Fetch inputs are ignored in the flush cycle. With an empty log, `flush` is a no-op and the FSM stays in `RUN`.
- FSM `UNWIND`:
  - Each cycle, take the tail entry and apply the inverse op: `PUSH`→`ras_pop`, `spec_depth--`; `POP`→`ras_push` with `ras_data=data`, `spec_depth++`; `NONE`→idle cycle. Then tail-- and count--.
  - `fetch_stall=1` and `pred_valid=0` throughout.
  - `commit_valid` and `flush` are ignored in this state.
  - When count reaches 0, return to `RUN`.
- Never drive `ras_push` and `ras_pop` in the same cycle.

## Timing
- All `ras_*`, `pred_*`, and `fetch_stall` outputs are combinational from state and inputs; the RAS samples them at the next posedge.
- Return prediction has zero-cycle latency: it is valid in the same cycle as `fetch_ret`.
- Unwinding takes exactly N cycles for N uncommitted entries. `fetch_stall` falls in the cycle the FSM is back in `RUN`.
- Reset values:
  - State `RUN`; log empty; `spec_depth=0`.
  - All outputs 0, including `ovf_err`.
- Reset mid-unwind aborts the unwind immediately. The RAS shares `rst` and returns to `EMPTY`, so both blocks stay consistent.
- Commit and flush in the same cycle: the commit retires the head first, then the remaining entries unwind.

## Configuration
- `RAS_CTRL_STATS_EN` defined: adds three 16-bit saturating counters, `stat_calls`, `stat_rets`, and `stat_unwind_cycles`. They are exposed as output ports, are reset to 0, and increment on issued push, issued pop, and `UNWIND` cycles respectively.
- Macro undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Structure
- Package `ras_pkg`: `ras_op_t` enum (`NONE`/`PUSH`/`POP`), `ras_log_entry_t` struct, `RAS_DEPTH` constant, and `ras_ctrl_state_t` enum (`RUN`/`UNWIND`).
- Sub-module `ras_log`: a circular deque with push-tail, pop-tail, and pop-head ports plus a count output.
- `ras_ctrl` holds the FSM, depth counter, and statistics.

## Test plan
- Calls at PCs 0x0100 and 0x0200, then two rets → pushes of 0x0101 and 0x0201; rets predict 0x0201 then 0x0101; `spec_depth` ends at 0.
- Eight calls, a ninth call, then five calls → no push on the ninth; `ovf_err`=1; `fetch_stall` asserts while the log is full.
- Call 0x0010, commit, call 0x0020, ret, flush → 2 unwind cycles (push 0x0021, then pop). Next ret predicts 0x0011.
- Ret at depth 0 → `pred_valid=0`, no pop, a `NONE` entry is logged; flush unwinds it in 1 idle cycle.
- Reset asserted during the second cycle of a 4-entry unwind → all outputs 0 and `RUN` the next cycle; RAS is empty.
- `RAS_CTRL_STATS_EN`: 3 calls, 1 ret, and a 3-entry flush → `stat_calls`=3, `stat_rets`=1, `stat_unwind_cycles`=3.
